fma_norm_round: RTL

Normalize-and-round back end of the FMA datapath: consumes the 3M+5-bit positive sum, sign and exponent produced by the adder stage and delivers a packed IEEE-754 result plus RISC-V fflags. Three-stage valid/ready pipeline: leading-zero count, normalizing shift, round and pack. Sits between the adder stage and the MAC writeback.

---
 rtl/fma_norm_round.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fma_norm_round.sv
// Normalize, round and pack back end of the FMA datapath.
// Three pipeline stages: leading-zero count, normalizing shift, round/pack.
module fma_norm_round #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic [3*PARM_MANT+4:0]        PosSum_i,
  input  logic                          Sign_i,
  input  logic [PARM_EXP+1:0]           Exp_i,
  input  logic                          Minus_sticky_bit_i,
  input  logic                          Eff_sub_i,
  input  logic [2:0]                    Rm_i,
  input  logic                          Special_i,
  input  logic [PARM_EXP+PARM_MANT:0]   Special_val_i,
  input  logic                          Special_nv_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Fflags_o
);
  localparam int M  = PARM_MANT;
  localparam int W  = 3*PARM_MANT+5;
  localparam int EW = PARM_EXP+2;
  localparam int XW = PARM_EXP+4;
  localparam int FW = PARM_EXP+PARM_MANT+1;
  localparam int LW = $clog2(W+1);

  logic w_en;
  assign w_en    = ~Valid_o | Ready_i;
  assign Ready_o = w_en;

  // ---------------- stage 1: leading-zero count ----------------
  logic [LW-1:0] w_lzc;
  always_comb begin
    w_lzc = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (PosSum_i[i]) w_lzc = LW'(W-1-i);
    end
  end

  logic          r_s1_valid, r_s1_sign, r_s1_msticky, r_s1_effsub, r_s1_zero;
  logic          r_s1_special, r_s1_spnv;
  logic [W-1:0]  r_s1_sum;
  logic [EW-1:0] r_s1_exp;
  logic [2:0]    r_s1_rm;
  logic [FW-1:0] r_s1_spval;
  logic [LW-1:0] r_s1_lzc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_msticky <= 1'b0;
      r_s1_effsub  <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_special <= 1'b0;
      r_s1_spnv    <= 1'b0;
      r_s1_sum     <= '0;
      r_s1_exp     <= '0;
      r_s1_rm      <= '0;
      r_s1_spval   <= '0;
      r_s1_lzc     <= '0;
    end else if (w_en) begin
      r_s1_valid   <= Valid_i;
      r_s1_sign    <= Sign_i;
      r_s1_msticky <= Minus_sticky_bit_i;
      r_s1_effsub  <= Eff_sub_i;
      r_s1_zero    <= ~(|PosSum_i) & ~Minus_sticky_bit_i;
      r_s1_special <= Special_i;
      r_s1_spnv    <= Special_nv_i;
      r_s1_sum     <= PosSum_i;
      r_s1_exp     <= Exp_i;
      r_s1_rm      <= Rm_i;
      r_s1_spval   <= Special_val_i;
      r_s1_lzc     <= w_lzc;
    end
  end

  // ---------------- stage 2: normalizing shift ----------------
  logic signed [XW-1:0] w_exp_x, w_ef, w_neg;
  logic                 w_ef_pos;
  logic [LW-1:0]        w_rsh;
  logic [W-1:0]         w_mant;
  logic                 w_lost;
  logic [XW-1:0]        w_expf;

  assign w_exp_x  = {{(XW-EW){r_s1_exp[EW-1]}}, r_s1_exp};
  assign w_ef     = w_exp_x + XW'(1) - {{(XW-LW){1'b0}}, r_s1_lzc};
  assign w_neg    = -w_exp_x;
  assign w_ef_pos = ~w_ef[XW-1] & (|w_ef);

  // Tiny results are aligned to the fixed subnormal scale instead of the leading one.
  always_comb begin
    w_mant = '0;
    w_lost = 1'b0;
    w_expf = '0;
    w_rsh  = '0;
    if (w_ef_pos) begin
      w_mant = r_s1_sum << r_s1_lzc;
      w_expf = w_ef;
    end else if (~w_exp_x[XW-1] & (|w_exp_x)) begin
      w_mant = r_s1_sum << w_exp_x[LW-1:0];
    end else begin
      w_rsh  = (w_neg >= XW'(W)) ? LW'(W) : w_neg[LW-1:0];
      w_mant = r_s1_sum >> w_rsh;
      w_lost = |(r_s1_sum & ~({W{1'b1}} << w_rsh));
    end
  end

  logic          r_s2_valid, r_s2_sign, r_s2_sticky, r_s2_effsub, r_s2_zero;
  logic          r_s2_special, r_s2_spnv;
  logic [W-1:0]  r_s2_mant;
  logic [XW-1:0] r_s2_exp;
  logic [2:0]    r_s2_rm;
  logic [FW-1:0] r_s2_spval;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_sticky  <= 1'b0;
      r_s2_effsub  <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_special <= 1'b0;
      r_s2_spnv    <= 1'b0;
      r_s2_mant    <= '0;
      r_s2_exp     <= '0;
      r_s2_rm      <= '0;
      r_s2_spval   <= '0;
    end else if (w_en) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_sticky  <= w_lost | r_s1_msticky;
      r_s2_effsub  <= r_s1_effsub;
      r_s2_zero    <= r_s1_zero;
      r_s2_special <= r_s1_special;
      r_s2_spnv    <= r_s1_spnv;
      r_s2_mant    <= w_mant;
      r_s2_exp     <= w_expf;
      r_s2_rm      <= r_s1_rm;
      r_s2_spval   <= r_s1_spval;
    end
  end

  // ---------------- stage 3: round and pack ----------------
  logic [M-1:0]    w_frac;
  logic            w_guard, w_stk, w_nx, w_inc, w_ovf, w_ovf_inf, w_uf, w_zsign;
  logic [XW+M-1:0] w_rnd;
  logic [XW-1:0]   w_rexp;

  assign w_frac  = r_s2_mant[W-2 -: M];
  assign w_guard = r_s2_mant[W-2-M];
  assign w_stk   = (|r_s2_mant[W-3-M:0]) | r_s2_sticky;
  assign w_nx    = w_guard | w_stk;

  always_comb begin
    w_inc     = 1'b0;
    w_ovf_inf = 1'b0;
    case (r_s2_rm)
      3'b000: begin w_inc = w_guard & (w_stk | w_frac[0]); w_ovf_inf = 1'b1;        end
      3'b010: begin w_inc = r_s2_sign & w_nx;              w_ovf_inf = r_s2_sign;   end
      3'b011: begin w_inc = ~r_s2_sign & w_nx;             w_ovf_inf = ~r_s2_sign;  end
      3'b100: begin w_inc = w_guard;                       w_ovf_inf = 1'b1;        end
      default: begin w_inc = 1'b0;                         w_ovf_inf = 1'b0;        end
    endcase
  end

  // Fraction carry ripples straight into the exponent field.
  assign w_rnd   = {r_s2_exp, w_frac} + (XW+M)'(w_inc);
  assign w_rexp  = w_rnd[XW+M-1:M];
  assign w_ovf   = w_rexp >= XW'((1 << PARM_EXP) - 1);
  assign w_uf    = w_nx & (r_s2_exp == '0);
  assign w_zsign = r_s2_effsub ? (r_s2_rm == 3'b010) : r_s2_sign;

  logic          r_valid_o;
  logic [FW-1:0] r_result;
  logic [4:0]    r_fflags;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_o <= 1'b0;
      r_result  <= '0;
      r_fflags  <= '0;
    end else if (w_en) begin
      r_valid_o <= r_s2_valid;
      if (r_s2_valid) begin
        if (r_s2_special) begin
          r_result <= r_s2_spval;
          r_fflags <= {r_s2_spnv, 4'b0000};
        end else if (r_s2_zero) begin
          r_result <= {w_zsign, {(FW-1){1'b0}}};
          r_fflags <= 5'b00000;
        end else if (w_ovf) begin
          r_result <= w_ovf_inf ? {r_s2_sign, {PARM_EXP{1'b1}}, {M{1'b0}}}
                                : {r_s2_sign, {(PARM_EXP-1){1'b1}}, 1'b0, {M{1'b1}}};
          r_fflags <= 5'b00101;
        end else begin
          r_result <= {r_s2_sign, w_rexp[PARM_EXP-1:0], w_rnd[M-1:0]};
          r_fflags <= {3'b000, w_uf, w_nx};
        end
      end
    end
  end

  assign Valid_o  = r_valid_o;
  assign Result_o = r_result;
  assign Fflags_o = r_fflags;
endmodule
